serial_add_ctrl: RTL and testbench

- Sequencer for bit-serial addition of two WIDTH-bit operands through a single 1-bit full-adder cell (full_adder: a, b, c -> sum, carry), one bit per clock, LSB first.
- Owns operand shift registers, carry flip-flop, bit counter and a start/busy/done handshake.
- Sits between a host register/FSM and the shared adder cell. Trades area for WIDTH-cycle latency.

---
 rtl/serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB first through one full-adder cell.
// Optional subtract mode (operand B inverted, carry seeded with 1) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Handshake: start is honoured only in IDLE; busy covers the WIDTH bit
  // cycles, then done pulses for exactly one cycle with sum/cout valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic fa_a, fa_b, fa_sum, fa_carry;

  always_comb begin
    fa_a = reg_a_q[0];
`ifdef SERIAL_ADD_SUB_EN
    fa_b = reg_b_q[0] ^ sub_q;
`else
    fa_b = reg_b_q[0];
`endif
    fa_sum   = fa_a ^ fa_b ^ carry_q;
    fa_carry = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  always_comb begin
    state_d = state_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          reg_a_d = a;
          reg_b_d = b;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
          carry_d = sub;
`else
          carry_d = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        reg_a_d = {1'b0, reg_a_q[WIDTH-1:1]};
        reg_b_d = {1'b0, reg_b_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        // Outputs are loaded on the last bit edge so done lands in the FIN cycle.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      reg_a_q <= '0;
      reg_b_q <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_sum_q;
  logic         exp_cout_q;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} from plain unsigned arithmetic.
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    logic [W-1:0] diff;
    if (s) begin
      diff = x - y;
      return {(x >= y), diff};
    end
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                        input string tag);
    logic [W:0] r;
    r = ref_result(av, bv, s);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int i = 1; i <= W; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done_early"}, done, 0);
      check({tag, "_sum_held"}, sum, exp_sum_q);
      if (i < W) @(negedge clk);
    end
    @(negedge clk);
    check({tag, "_busy_fin"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, r[W-1:0]);
    check({tag, "_cout"}, cout, r[W]);
    exp_sum_q  = r[W-1:0];
    exp_cout_q = r[W];
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_cout_held"}, cout, exp_cout_q);
  endtask

  initial begin
    int           ndone;
    int           done_cyc;
    int           dcyc[$];
    logic [W-1:0] ra, rb;
    logic         rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    exp_sum_q = '0; exp_cout_q = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    run_op(8'd100, 8'd27, 1'b0, "add_100_27");
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'hFF, 8'hFF, 1'b0, "add_ff_ff");
    run_op(8'h00, 8'h00, 1'b0, "add_00_00");

    // start pulsed mid-operation must be ignored
    ndone = 0; done_cyc = -1;
    @(negedge clk);
    a = 8'd3; b = 8'd4; start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = (cyc == 3);
      if (cyc == 3) begin a = 8'd9; b = 8'd9; end
      if (done) begin
        ndone++; done_cyc = cyc;
        check("ign_sum", sum, 7);
        check("ign_cout", cout, 0);
      end
    end
    check("ign_done_count", ndone, 1);
    check("ign_done_cycle", done_cyc, W + 1);
    exp_sum_q = 8'd7; exp_cout_q = 1'b0;

    // reset in the middle of an operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    check("mid_rst_busy_idle", busy, 0);
    exp_sum_q = '0; exp_cout_q = 1'b0;
    run_op(8'd1, 8'd2, 1'b0, "after_rst");

    // start held high across two back-to-back operations
    exp_q.push_back(8'd11);
    exp_q.push_back(8'd30);
    @(negedge clk);
    a = 8'd5; b = 8'd6; start = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin a = 8'd10; b = 8'd20; end
      if (cyc == 15) start = 1'b0;
      check("held_busy_done_excl", busy & done, 0);
      if (done) begin
        dcyc.push_back(cyc);
        check("held_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("held_sum", sum, exp_q.pop_front());
      end
    end
    check("held_done_count", dcyc.size(), 2);
    if (dcyc.size() == 2) begin
      check("held_first_done", dcyc[0], W + 1);
      check("held_spacing", dcyc[1] - dcyc[0], W + 2);
    end
    exp_sum_q = 8'd30; exp_cout_q = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'd5, 8'd7, 1'b1, "sub_5_7");
    run_op(8'd7, 8'd5, 1'b1, "sub_7_5");
`endif

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, rs, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
